uabc_reloj_gen: RTL and testbench
=================================

# uabc_reloj_gen

Parametrised second-generation real-time clock core for the UABC clock project. Keeps hours, minutes and seconds as BCD digits from an internal prescaler, adds a seconds field, selectable 12/24-hour display, button-driven time setting and a single alarm with timed output. Sits directly under the Tiny Tapeout top wrapper; its BCD outputs feed the 7-segment drivers and dot LEDs.

## Interface
Parameters:
- TICK_DIV, 12_000_000: clk cycles per second; minimum 2, must be even.
- ALARM_SECS, 30: seconds the alarm output stays high once triggered; range 1..59.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- set_mode  in  1  level; halts timekeeping; buttons edit time.
- alarm_set  in  1  level; buttons edit alarm registers; overrides set_mode for button routing.
- btn_min  in  1  minute button, already synchronised; acts on rising edge.
- btn_hr  in  1  hour button, already synchronised; acts on rising edge.
- fmt12  in  1  1 = 12-hour display, 0 = 24-hour.
- alarm_en  in  1  arms the alarm.
- S0, S1  out  4, 4  seconds BCD, units and tens.
- M0, M1  out  4, 4  minutes BCD, shown digits (alarm minutes while alarm_set=1).
- H0  out  4  hours units BCD.
- H1  out  2  hours tens BCD.
- pm  out  1  1 when fmt12=1 and shown hour ≥ 12; 0 in 24-hour mode.
- Dots  out  1  1 Hz blink.
- alarm  out  1  alarm active.

## Operation
- Internal state: 2-digit BCD counters sec (mod 60), min (mod 60), hr (mod 24), a_min, a_hr; prescaler pre (0..TICK_DIV-1); alarm seconds counter acnt; previous-button registers for edge detection.
- Time is always stored in 24-hour form; 12-hour conversion affects display only: 00→12 AM, 01–11 unchanged AM, 12→12 PM, 13–23→01–11 PM.
- Run (set_mode=0): pre increments each cycle; at pre=TICK_DIV-1 a tick occurs, pre→0, sec increments; 59→00 carries to min; min 59→00 carries to hr; hr 23→00.
- Set (set_mode=1): pre held at 0, sec held at 00; no ticks. When set_mode falls, counting resumes from pre=0.
- Buttons act only when set_mode=1 or alarm_set=1. Target = alarm registers if alarm_set=1, else time registers. btn_min edge: minute +1, 59→00, no carry to hour. btn_hr edge: hour +1, 23→00. Both edges in the same cycle: both fields increment.
- alarm_set=1 with set_mode=0: time keeps running; only the display switches to alarm values (S0/S1 show 0).
- Trigger: on the tick that makes sec=00 while alarm_en=1 and the new {hr,min} equals {a_hr,a_min}, alarm→1 and acnt→0. Each later tick increments acnt; alarm→0 on the tick where acnt reaches ALARM_SECS-1.
- Alarm clears immediately, next cycle, on alarm_en=0, any button edge, or set_mode=1. It is not retriggered until the next match.
- Dots = 1 while pre < TICK_DIV/2, else 0. Forced to 1 in set_mode.

## Timing
- Reset (async assert, synchronous release): all counters 0; a_hr=00, a_min=00. Outputs: S/M/H=0, H displayed 12 with pm=0 if fmt12=1. alarm=0, Dots=1.
- Counters update on the tick cycle's clock edge. Display outputs are combinational from the registers plus fmt12 and alarm_set, with zero added latency.
- A button edge is seen one cycle after the input rises, from the registered previous value, and updates the register on that edge.
- alarm rises on the same edge that writes sec=00.
- Reset asserted mid-alarm or mid-set clears everything at once; alarm registers are not retained.

## Structure
- Package uabc_reloj_pkg: BCD digit typedef, MOD60/MOD24 constants, function bcd24_to_12 (hour BCD → display BCD + pm).
- Sub-module bcd2_counter: 2-digit BCD counter with MOD parameter, inc input, wrap output and synchronous clear. Instantiated five times (sec, min, hr, a_min, a_hr).

## Test plan
- TICK_DIV=4, reset, run 240 cycles → S1:S0 = 6:0→ reads 01:00 (M0=1, S=00); Dots high 2 cycles, low 2 cycles.
- Set time 23:59 via set_mode and buttons, release, run 60 ticks → 00:00:00. With fmt12=1 → H1:H0=12, pm=0.
- Time 13:05, fmt12=1 → H=01, pm=1. Toggle fmt12=0 → H=13, pm=0 in the same cycle.
- alarm_set=1, set alarm to 00:02, alarm_en=1, run from 00:01:58 → alarm rises at 00:02:00 and stays high exactly ALARM_SECS ticks.
- Alarm active, pulse btn_min with set_mode=0 → alarm=0 next cycle, time unchanged.
- Assert rst_n=0 mid-count at 07:30:15 → all outputs at reset values without waiting for a clk edge.

Source files
------------

// File: rtl/uabc_reloj_gen_pkg.sv
// Shared types and helpers for the UABC real-time clock core.
// Hours are stored in 24-hour BCD; the 12-hour view is derived for display only.
package uabc_reloj_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd2_t;

  typedef struct packed {
    logic  pm;
    bcd2_t hr;
  } hr12_t;

  typedef enum logic {AL_IDLE, AL_RING} al_state_t;

  localparam int MOD60 = 60;
  localparam int MOD24 = 24;

  // 00 -> 12 AM, 01..11 AM, 12 -> 12 PM, 13..23 -> 01..11 PM
  function automatic hr12_t bcd24_to_12(input bcd2_t h);
    logic [4:0] hb;
    logic [4:0] h12;
    hr12_t      r;
    hb    = 5'(h.tens) * 5'd10 + 5'(h.units);
    r.pm  = (hb >= 5'd12);
    h12   = r.pm ? (hb - 5'd12) : hb;
    if (h12 == 5'd0) h12 = 5'd12;
    r.hr.tens  = (h12 >= 5'd10) ? 4'd1 : 4'd0;
    r.hr.units = (h12 >= 5'd10) ? 4'(h12 - 5'd10) : 4'(h12);
    return r;
  endfunction

endpackage

// File: rtl/uabc_reloj_gen_if.sv
// Control inputs and display outputs of the clock core, grouped as one bundle.
interface uabc_reloj_gen_if;
  import uabc_reloj_pkg::*;

  logic       set_mode;
  logic       alarm_set;
  logic       btn_min;
  logic       btn_hr;
  logic       fmt12;
  logic       alarm_en;
  bcd_t       S0;
  bcd_t       S1;
  bcd_t       M0;
  bcd_t       M1;
  bcd_t       H0;
  logic [1:0] H1;
  logic       pm;
  logic       Dots;
  logic       alarm;

  modport master (
    output set_mode, alarm_set, btn_min, btn_hr, fmt12, alarm_en,
    input  S0, S1, M0, M1, H0, H1, pm, Dots, alarm
  );

  modport slave (
    input  set_mode, alarm_set, btn_min, btn_hr, fmt12, alarm_en,
    output S0, S1, M0, M1, H0, H1, pm, Dots, alarm
  );
endinterface

// File: rtl/uabc_reloj_gen_bcd2_counter.sv
// Two-digit BCD counter modulo MOD with increment, synchronous clear and
// a combinational next-value output so callers can compare against it.
module bcd2_counter
  import uabc_reloj_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  inc,
  output bcd2_t q,
  output bcd2_t nxt,
  output logic  wrap
);

  localparam bcd_t TMAX = bcd_t'((MOD - 1) / 10);
  localparam bcd_t UMAX = bcd_t'((MOD - 1) % 10);

  logic at_max;

  assign at_max = (q.tens == TMAX) && (q.units == UMAX);
  assign wrap   = inc & at_max;

  always_comb begin
    nxt = q;
    if (clr) begin
      nxt = '0;
    end else if (inc) begin
      if (at_max) begin
        nxt = '0;
      end else if (q.units == 4'd9) begin
        nxt.units = 4'd0;
        nxt.tens  = q.tens + 4'd1;
      end else begin
        nxt.units = q.units + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end

endmodule

// File: rtl/uabc_reloj_gen.sv
// Real-time clock core: prescaled BCD time of day, button time/alarm setting,
// one alarm with a timed output and a 12/24-hour display view.
module uabc_reloj_gen
  import uabc_reloj_pkg::*;
#(
  parameter int TICK_DIV   = 12_000_000,
  parameter int ALARM_SECS = 30
) (
  input logic              clk,
  input logic              rst_n,
  uabc_reloj_gen_if.slave  bus
);

  localparam int              PRE_W      = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF  = PRE_W'(TICK_DIV / 2);
  localparam logic [5:0]       ACNT_LAST = 6'(ALARM_SECS - 1);

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             min_prev, hr_prev, min_edge, hr_edge;
  logic             edit_time, edit_alarm;
  bcd2_t            sec_q, min_q, hr_q, amin_q, ahr_q;
  bcd2_t            sec_nxt, min_nxt, hr_nxt, amin_nxt, ahr_nxt;
  logic             sec_wrap, min_wrap, hr_wrap, amin_wrap, ahr_wrap;
  al_state_t        st, st_nxt;
  logic [5:0]       acnt, acnt_nxt;
  logic             al_clear, al_match;
  bcd2_t            h_show, m_show;
  hr12_t            h12;
  bcd_t             h_tens;
  logic             unused_bits;

  // Prescaler: held at zero while setting so counting restarts cleanly.
  assign tick = !bus.set_mode && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     pre <= '0;
    else if (bus.set_mode || tick)  pre <= '0;
    else                            pre <= pre + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_prev <= 1'b0;
      hr_prev  <= 1'b0;
    end else begin
      min_prev <= bus.btn_min;
      hr_prev  <= bus.btn_hr;
    end
  end

  assign min_edge   = bus.btn_min & ~min_prev;
  assign hr_edge    = bus.btn_hr  & ~hr_prev;
  assign edit_alarm = bus.alarm_set;
  assign edit_time  = bus.set_mode & ~bus.alarm_set;

  bcd2_counter #(.MOD(MOD60)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(bus.set_mode), .inc(tick),
    .q(sec_q), .nxt(sec_nxt), .wrap(sec_wrap)
  );

  // Button increments of minutes must not carry, so the hour carry needs sec_wrap.
  bcd2_counter #(.MOD(MOD60)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(sec_wrap | (edit_time & min_edge)),
    .q(min_q), .nxt(min_nxt), .wrap(min_wrap)
  );

  bcd2_counter #(.MOD(MOD24)) u_hr (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .inc((sec_wrap & min_wrap) | (edit_time & hr_edge)),
    .q(hr_q), .nxt(hr_nxt), .wrap(hr_wrap)
  );

  bcd2_counter #(.MOD(MOD60)) u_amin (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(edit_alarm & min_edge),
    .q(amin_q), .nxt(amin_nxt), .wrap(amin_wrap)
  );

  bcd2_counter #(.MOD(MOD24)) u_ahr (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(edit_alarm & hr_edge),
    .q(ahr_q), .nxt(ahr_nxt), .wrap(ahr_wrap)
  );

  // Match against the values being written so alarm rises with sec=00.
  assign al_clear = ~bus.alarm_en | min_edge | hr_edge | bus.set_mode;
  assign al_match = sec_wrap & bus.alarm_en & (min_nxt == amin_q) & (hr_nxt == ahr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= AL_IDLE;
      acnt <= '0;
    end else begin
      st   <= st_nxt;
      acnt <= acnt_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    acnt_nxt = acnt;
    if (al_clear) begin
      st_nxt = AL_IDLE;
    end else if (al_match) begin
      st_nxt   = AL_RING;
      acnt_nxt = '0;
    end else if (st == AL_RING && tick) begin
      if (acnt == ACNT_LAST) st_nxt   = AL_IDLE;
      else                   acnt_nxt = acnt + 6'd1;
    end
  end

  always_comb begin
    h_show = bus.alarm_set ? ahr_q  : hr_q;
    m_show = bus.alarm_set ? amin_q : min_q;
    h12    = bcd24_to_12(h_show);
    h_tens = bus.fmt12 ? h12.hr.tens : h_show.tens;
  end

  assign bus.S0    = bus.alarm_set ? 4'd0 : sec_q.units;
  assign bus.S1    = bus.alarm_set ? 4'd0 : sec_q.tens;
  assign bus.M0    = m_show.units;
  assign bus.M1    = m_show.tens;
  assign bus.H0    = bus.fmt12 ? h12.hr.units : h_show.units;
  assign bus.H1    = h_tens[1:0];
  assign bus.pm    = bus.fmt12 & h12.pm;
  assign bus.Dots  = bus.set_mode | (pre < PRE_HALF);
  assign bus.alarm = (st == AL_RING);

  assign unused_bits = ^{sec_nxt, amin_nxt, ahr_nxt, hr_wrap, amin_wrap, ahr_wrap, h_tens[3:2]};

endmodule

// File: tb/tb_uabc_reloj_gen.sv
// Bench for uabc_reloj_gen: directed scenarios plus randomized control activity,
// all outputs checked every cycle against a seconds-of-day reference model.
module tb_uabc_reloj_gen;

  localparam int TD = 4;
  localparam int AS = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uabc_reloj_gen_if bus();

  uabc_reloj_gen #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int ncmp  = 0;
  int nfail = 0;

  // Reference state: time as seconds of day, alarm as minutes of day.
  int t, am, pre, acnt;
  bit alm, pmin, phr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] dut_outs();
    return {bus.S1, bus.S0, bus.M1, bus.M0, bus.H1, bus.H0, bus.pm, bus.Dots, bus.alarm};
  endfunction

  function automatic logic [24:0] exp_outs();
    int h, m, s, dh;
    bit pmv, dots;
    h    = bus.alarm_set ? am / 60 : t / 3600;
    m    = bus.alarm_set ? am % 60 : (t / 60) % 60;
    s    = bus.alarm_set ? 0 : t % 60;
    dh   = bus.fmt12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    pmv  = bus.fmt12 && (h >= 12);
    dots = bus.set_mode || (pre < TD / 2);
    return {4'(s / 10), 4'(s % 10), 4'(m / 10), 4'(m % 10), 2'(dh / 10), 4'(dh % 10),
            pmv, dots, alm};
  endfunction

  task automatic model_reset();
    t = 0; am = 0; pre = 0; acnt = 0; alm = 0; pmin = 0; phr = 0;
  endtask

  task automatic model_step();
    bit em, eh, tk, clr;
    em = bus.btn_min && !pmin;
    eh = bus.btn_hr  && !phr;
    tk = 0;
    if (bus.set_mode) begin
      pre = 0;
      t   = t - t % 60;
    end else if (pre == TD - 1) begin
      pre = 0;
      tk  = 1;
      t   = (t + 1) % 86400;
    end else begin
      pre++;
    end
    if (bus.alarm_set) begin
      if (em) am = (am / 60) * 60 + (am % 60 + 1) % 60;
      if (eh) am = ((am / 60 + 1) % 24) * 60 + am % 60;
    end else if (bus.set_mode) begin
      if (em) t = (t / 3600) * 3600 + (((t / 60) % 60 + 1) % 60) * 60 + t % 60;
      if (eh) t = ((t / 3600 + 1) % 24) * 3600 + t % 3600;
    end
    clr = !bus.alarm_en || em || eh || bus.set_mode;
    if (clr) begin
      alm = 0;
    end else if (tk && t % 60 == 0 && bus.alarm_en && t / 60 == am) begin
      alm  = 1;
      acnt = 0;
    end else if (alm && tk) begin
      if (acnt == AS - 1) alm = 0;
      else                acnt++;
    end
    pmin = bus.btn_min;
    phr  = bus.btn_hr;
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      chk(tag, 32'(dut_outs()), 32'(exp_outs()));
    end
  endtask

  task automatic press_min(input int n);
    repeat (n) begin
      bus.btn_min = 1'b1; step(1, "press_min");
      bus.btn_min = 1'b0; step(1, "press_min");
    end
  endtask

  task automatic press_hr(input int n);
    repeat (n) begin
      bus.btn_hr = 1'b1; step(1, "press_hr");
      bus.btn_hr = 1'b0; step(1, "press_hr");
    end
  endtask

  initial begin
    int k;
    rst_n         = 1'b0;
    bus.set_mode  = 1'b0;
    bus.alarm_set = 1'b0;
    bus.btn_min   = 1'b0;
    bus.btn_hr    = 1'b0;
    bus.fmt12     = 1'b0;
    bus.alarm_en  = 1'b0;
    model_reset();
    #2;
    chk("rst_S", {bus.S1, bus.S0}, 0);
    chk("rst_M", {bus.M1, bus.M0}, 0);
    chk("rst_H", {bus.H1, bus.H0}, 0);
    chk("rst_dots", bus.Dots, 1);
    chk("rst_alarm", bus.alarm, 0);
    bus.fmt12 = 1'b1; #1;
    chk("rst_H12", {bus.H1, bus.H0}, 6'h12);
    chk("rst_pm", bus.pm, 0);
    bus.fmt12 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Dots: high while pre is 0/1, low while 2/3
    for (int i = 0; i < 4; i++) begin
      step(1, "dots_run");
      chk("dots_phase", bus.Dots, (i == 1 || i == 2) ? 0 : 1);
    end
    step(236, "run");
    chk("run240_M", {bus.M1, bus.M0}, 8'h01);
    chk("run240_S", {bus.S1, bus.S0}, 8'h00);

    // 23:59 then one minute of ticks
    bus.set_mode = 1'b1; step(1, "set");
    press_hr(23);
    press_min(58);
    chk("set_2359", {bus.H1, bus.H0, bus.M1, bus.M0}, {2'd2, 4'd3, 4'd5, 4'd9});
    bus.set_mode = 1'b0;
    step(240, "run_wrap");
    chk("wrap_HMS", {bus.H1, bus.H0, bus.M1, bus.M0, bus.S1, bus.S0}, 0);
    bus.fmt12 = 1'b1; #1;
    chk("wrap_H12", {bus.H1, bus.H0}, 6'h12);
    chk("wrap_pm", bus.pm, 0);
    bus.fmt12 = 1'b0;

    // 13:05 in both display formats
    bus.set_mode = 1'b1; step(1, "set");
    press_hr(13);
    press_min(5);
    bus.fmt12 = 1'b1; #1;
    chk("h13_fmt12_H", {bus.H1, bus.H0}, 6'h01);
    chk("h13_fmt12_pm", bus.pm, 1);
    bus.fmt12 = 1'b0; #1;
    chk("h13_fmt24_H", {bus.H1, bus.H0}, 6'h13);
    chk("h13_fmt24_pm", bus.pm, 0);

    // Alarm at 00:02, run from 00:01:58
    bus.alarm_set = 1'b1; #1;
    chk("aset_show", {bus.H1, bus.H0, bus.M1, bus.M0, bus.S1, bus.S0}, 0);
    press_min(2);
    chk("aset_0002", {bus.H1, bus.H0, bus.M1, bus.M0}, 14'h0002);
    bus.alarm_set = 1'b0;
    press_hr(11);
    press_min(56);
    bus.set_mode = 1'b0;
    bus.alarm_en = 1'b1;
    step(232, "run_alarm");
    chk("t000158", {bus.H1, bus.H0, bus.M1, bus.M0, bus.S1, bus.S0},
        {2'd0, 4'd0, 4'd0, 4'd1, 4'd5, 4'd8});
    step(7, "pre_alarm");
    chk("alarm_before", bus.alarm, 0);
    step(1, "alarm_edge");
    chk("alarm_rise", bus.alarm, 1);
    chk("alarm_rise_time", {bus.H1, bus.H0, bus.M1, bus.M0, bus.S1, bus.S0}, 22'h00200);
    step(AS * TD - 1, "alarm_hold");
    chk("alarm_last", bus.alarm, 1);
    step(1, "alarm_end");
    chk("alarm_fall", bus.alarm, 0);

    // Button edge clears a ringing alarm without touching time
    bus.alarm_set = 1'b1;
    press_min(1);
    bus.alarm_set = 1'b0;
    k = 0;
    while (bus.alarm !== 1'b1 && k < 400) begin
      step(1, "wait_alarm");
      k++;
    end
    chk("alarm2_seen", bus.alarm, 1);
    bus.btn_min = 1'b1;
    step(1, "btn_clear");
    chk("btnclr_alarm", bus.alarm, 0);
    chk("btnclr_min", {bus.M1, bus.M0}, 8'h03);
    bus.btn_min = 1'b0;
    step(2, "btn_release");

    // Randomized control activity
    for (int i = 0; i < 120; i++) begin
      bus.set_mode  = ($urandom_range(0, 9) == 0);
      bus.alarm_set = ($urandom_range(0, 5) == 0);
      bus.btn_min   = ($urandom_range(0, 2) == 0);
      bus.btn_hr    = ($urandom_range(0, 3) == 0);
      bus.fmt12     = 1'($urandom);
      bus.alarm_en  = ($urandom_range(0, 3) != 0);
      step($urandom_range(1, 12), "rand");
    end

    // 07:30:15 then asynchronous reset
    bus.btn_min   = 1'b0;
    bus.btn_hr    = 1'b0;
    bus.alarm_set = 1'b0;
    bus.alarm_en  = 1'b0;
    bus.fmt12     = 1'b0;
    bus.set_mode  = 1'b1;
    step(1, "set");
    press_hr((7 - t / 3600 + 24) % 24);
    press_min((30 - (t / 60) % 60 + 60) % 60);
    bus.set_mode = 1'b0;
    step(60, "run_0730");
    chk("t073015", {bus.H1, bus.H0, bus.M1, bus.M0, bus.S1, bus.S0},
        {2'd0, 4'd7, 4'd3, 4'd0, 4'd1, 4'd5});
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", 32'(dut_outs()), 32'd2);
    model_reset();
    chk("arst_model", 32'(dut_outs()), 32'(exp_outs()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
